// File: rtl/pc_fetch_if.sv
// Fetch-side bus of the PC sequencer: instruction-memory request/response
// plus the valid/ready hand-off of fetched instructions to decode.
interface pc_fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) ();
  logic               req_valid;
  logic [PC_W-1:0]    req_addr;
  logic               req_ready;
  logic               rsp_valid;
  logic [INSTR_W-1:0] rsp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  // Fetch controller side
  modport master (
    output req_valid, req_addr, instr_valid, instr, instr_pc,
    input  req_ready, rsp_valid, rsp_data, instr_ready
  );

  // Memory / decode side
  modport slave (
    input  req_valid, req_addr, instr_valid, instr, instr_pc,
    output req_ready, rsp_valid, rsp_data, instr_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and single-outstanding fetch sequencer. The PC feeds an
// external combinational +1 incrementer whose sum returns as pc_plus1_i.
// Fetched instructions are held and offered to decode with their PC.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc_o,
  input  logic [PC_W-1:0] pc_plus1_i,
  pc_fetch_if.master      bus,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            halted_o,
  output logic            wrap_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               drop_q, drop_d;
  logic               wrap_q, wrap_d;
  logic               req_valid_q, instr_valid_q, halted_q;

  // Next-state, PC and instruction-buffer selection; redirect overrides halt
  // and every normal transition.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    drop_d     = drop_q;
    wrap_d     = 1'b0;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      case (state_q)
        // An accepted request, or one still awaiting its response, leaves a
        // response owed by memory that must be swallowed in DRAIN.
        S_REQ: begin
          if (bus.req_ready) begin
            state_d = S_DRAIN;
            drop_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_DRAIN;
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (halt_i) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.req_ready) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            instr_d    = bus.rsp_data;
            instr_pc_d = pc_q;
            state_d    = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            pc_d   = pc_plus1_i;
            wrap_d = (pc_q == {PC_W{1'b1}});
            if (halt_i) begin
              state_d = S_HALTED;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (bus.rsp_valid && drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
        default: begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

  // State, PC, instruction buffer and state-decoded outputs, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= {INSTR_W{1'b0}};
      instr_pc_q    <= {PC_W{1'b0}};
      drop_q        <= 1'b0;
      wrap_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      drop_q        <= drop_d;
      wrap_q        <= wrap_d;
      req_valid_q   <= (state_d == S_REQ);
      instr_valid_q <= (state_d == S_HOLD);
      halted_q      <= (state_d == S_HALTED);
    end
  end

  assign pc_o            = pc_q;
  assign bus.req_addr    = pc_q;
  assign bus.req_valid   = req_valid_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign halted_o        = halted_q;
  assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: a transaction-level model of the fetch sequencer
// checked every cycle, directed scenarios with literal expectations, and a
// second instance built with RESET_PC=8'hFE for the wrap-around case.
module tb_pc_fetch_ctrl;
  logic clk;
  logic rst, rst2;
  logic [7:0] pc, pc_plus1, pc2, pc2_plus1;
  logic redirect, halt, halted, wrap;
  logic [7:0] redirect_pc;
  logic halted2, wrap2;
  int n_checks = 0;
  int n_err = 0;
  int mem_lat = 1;
  bit chk_en = 1'b0;
  int wrap_cnt = 0;
  int wrap2_cnt = 0;
  logic [7:0] acc_q[$];
  logic [7:0] acc2_q[$];

  pc_fetch_if #(.PC_W(8), .INSTR_W(16)) bus ();
  pc_fetch_if #(.PC_W(8), .INSTR_W(16)) bus2 ();

  pc_fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .pc_o(pc), .pc_plus1_i(pc_plus1), .bus(bus),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
    .halted_o(halted), .wrap_o(wrap)
  );

  pc_fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u_dut_wrap (
    .clk(clk), .rst(rst2), .pc_o(pc2), .pc_plus1_i(pc2_plus1), .bus(bus2),
    .redirect_i(1'b0), .redirect_pc_i(8'h00), .halt_i(1'b0),
    .halted_o(halted2), .wrap_o(wrap2)
  );

  // External incrementers
  assign pc_plus1  = pc + 8'd1;
  assign pc2_plus1 = pc2 + 8'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_instr(input logic [7:0] want, input int max);
    int n = 0;
    while (!(bus.instr_valid === 1'b1 && bus.instr_pc === want) && n < max) begin
      cyc(1);
      n++;
    end
    check("wait_instr_in_time", 32'(n < max), 32'd1);
  endtask

  // Instruction memory for the main DUT: single outstanding, latency mem_lat.
  int pend_cnt = 0;
  logic [7:0] pend_addr = 8'h00;
  always begin
    logic fire;
    logic [7:0] faddr;
    @(posedge clk);
    fire  = (bus.req_valid === 1'b1) && (bus.req_ready === 1'b1);
    faddr = bus.req_addr;
    #1;
    bus.rsp_valid = 1'b0;
    if (fire) begin
      acc_q.push_back(faddr);
      pend_addr = faddr;
      pend_cnt  = mem_lat;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(pend_addr);
      end
    end
  end

  // Instruction memory for the wrap DUT: always ready, one-cycle latency.
  always begin
    logic fire2;
    logic [7:0] faddr2;
    @(posedge clk);
    fire2  = (bus2.req_valid === 1'b1);
    faddr2 = bus2.req_addr;
    #1;
    bus2.rsp_valid = fire2;
    bus2.rsp_data  = mem_word(faddr2);
    if (fire2) acc2_q.push_back(faddr2);
  end

  // Transaction-level reference: flags for "request pending", "response
  // owed", "instruction held", "stale response owed", "halted", "idle".
  logic [7:0]  m_pc = 8'h00, m_ipc = 8'h00;
  logic [15:0] m_instr = 16'h0000;
  logic m_req = 1'b0, m_out = 1'b0, m_have = 1'b0, m_stale = 1'b0;
  logic m_halted = 1'b0, m_idle = 1'b1, m_wrap = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 8'h00; m_ipc <= 8'h00; m_instr <= 16'h0000;
      m_req <= 1'b0; m_out <= 1'b0; m_have <= 1'b0; m_stale <= 1'b0;
      m_halted <= 1'b0; m_idle <= 1'b1; m_wrap <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      if (redirect) begin
        m_pc <= redirect_pc;
        m_have <= 1'b0; m_halted <= 1'b0; m_idle <= 1'b0; m_out <= 1'b0;
        if ((m_req && bus.req_ready) || (m_out && !bus.rsp_valid)) begin
          m_stale <= 1'b1; m_req <= 1'b0;
        end else begin
          m_stale <= 1'b0; m_req <= 1'b1;
        end
      end else if (m_idle) begin
        m_idle <= 1'b0;
        if (halt) m_halted <= 1'b1;
        else m_req <= 1'b1;
      end else if (m_req) begin
        if (bus.req_ready) begin m_req <= 1'b0; m_out <= 1'b1; end
      end else if (m_out) begin
        if (bus.rsp_valid) begin
          m_out <= 1'b0; m_have <= 1'b1; m_instr <= bus.rsp_data; m_ipc <= m_pc;
        end
      end else if (m_have) begin
        if (bus.instr_ready) begin
          m_have <= 1'b0;
          m_wrap <= (m_pc == 8'hFF);
          m_pc <= m_pc + 8'd1;
          if (halt) m_halted <= 1'b1;
          else m_req <= 1'b1;
        end
      end else if (m_stale) begin
        if (bus.rsp_valid) begin m_stale <= 1'b0; m_req <= 1'b1; end
      end
    end
  end

  // Every-cycle comparison against the reference, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_valid", 32'(bus.req_valid), 32'(m_req));
      check("req_addr", 32'(bus.req_addr), 32'(m_pc));
      check("pc", 32'(pc), 32'(m_pc));
      check("instr_valid", 32'(bus.instr_valid), 32'(m_have));
      check("instr", 32'(bus.instr), 32'(m_instr));
      check("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
      check("halted", 32'(halted), 32'(m_halted));
      check("wrap", 32'(wrap), 32'(m_wrap));
      if (wrap === 1'b1) wrap_cnt++;
      if (wrap2 === 1'b1) begin
        wrap2_cnt++;
        check("wrap2_pc", 32'(pc2), 32'h00);
        check("wrap2_instr_pc", 32'(bus2.instr_pc), 32'hFF);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
    bus.req_ready = 1'b1; bus.instr_ready = 1'b1;
    bus.rsp_valid = 1'b0; bus.rsp_data = 16'h0000;
    bus2.req_ready = 1'b1; bus2.instr_ready = 1'b1;
    bus2.rsp_valid = 1'b0; bus2.rsp_data = 16'h0000;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    check("reset_req_valid", 32'(bus.req_valid), 32'd0);
    check("reset_pc", 32'(pc), 32'h00);
    check("reset_instr", 32'(bus.instr), 32'h0000);

    // Reset then run: first request one cycle after reset release.
    rst = 1'b0;
    acc_q.delete();
    cyc(1);
    check("first_req_valid", 32'(bus.req_valid), 32'd1);
    check("first_req_addr", 32'(bus.req_addr), 32'h00);
    for (int i = 0; i < 30 && acc_q.size() < 4; i++) cyc(1);
    check("run_accepts", 32'(acc_q.size() >= 4), 32'd1);
    if (acc_q.size() >= 4) begin
      check("run_addr0", 32'(acc_q[0]), 32'h00);
      check("run_addr1", 32'(acc_q[1]), 32'h01);
      check("run_addr2", 32'(acc_q[2]), 32'h02);
      check("run_addr3", 32'(acc_q[3]), 32'h03);
    end

    // Backpressure at PC 05.
    wait_instr(8'h05, 30);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_instr", 32'(bus.instr), 32'hFA05);
      check("bp_pc", 32'(bus.instr_pc), 32'h05);
      check("bp_no_req", 32'(bus.req_valid), 32'd0);
    end
    bus.instr_ready = 1'b1;
    cyc(1);
    check("bp_next_req", 32'(bus.req_valid), 32'd1);
    check("bp_next_addr", 32'(bus.req_addr), 32'h06);

    // Redirect in REQ while memory is not ready.
    bus.req_ready = 1'b0;
    cyc(1);
    check("stall_addr", 32'(bus.req_addr), 32'h06);
    redirect = 1'b1; redirect_pc = 8'h10;
    cyc(1);
    redirect = 1'b0;
    check("redir_req_valid", 32'(bus.req_valid), 32'd1);
    check("redir_req_addr", 32'(bus.req_addr), 32'h10);

    // Redirect in WAIT: the response for 10 arrives in DRAIN and is dropped.
    mem_lat = 2; bus.req_ready = 1'b1;
    cyc(1);
    check("wait_no_req", 32'(bus.req_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 8'h40;
    cyc(1);
    redirect = 1'b0; mem_lat = 1;
    check("drain_no_req", 32'(bus.req_valid), 32'd0);
    check("drain_no_instr", 32'(bus.instr_valid), 32'd0);
    cyc(1);
    check("post_drain_req", 32'(bus.req_valid), 32'd1);
    check("post_drain_addr", 32'(bus.req_addr), 32'h40);
    wait_instr(8'h40, 10);
    check("redir_instr", 32'(bus.instr), 32'hBF40);

    // Halt on the hand-off at PC 07, then leave HALTED by redirect.
    redirect = 1'b1; redirect_pc = 8'h07;
    cyc(1);
    redirect = 1'b0;
    wait_instr(8'h07, 10);
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    check("halted", 32'(halted), 32'd1);
    check("halted_pc", 32'(pc), 32'h08);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("halted_no_req", 32'(bus.req_valid), 32'd0);
    end
    redirect = 1'b1; redirect_pc = 8'h20;
    cyc(1);
    redirect = 1'b0;
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_req", 32'(bus.req_valid), 32'd1);
    check("unhalt_addr", 32'(bus.req_addr), 32'h20);

    // Wrap through FF on the main instance (request at 20 goes to DRAIN).
    redirect = 1'b1; redirect_pc = 8'hFE;
    cyc(1);
    redirect = 1'b0;
    cyc(15);
    check("wrap_count", 32'(wrap_cnt), 32'd1);

    // Reset mid-operation.
    rst = 1'b1;
    cyc(1);
    check("midrst_req", 32'(bus.req_valid), 32'd0);
    check("midrst_pc", 32'(pc), 32'h00);
    rst = 1'b0;
    cyc(1);
    check("midrst_resume", 32'(bus.req_valid), 32'd1);
    cyc(6);

    // Wrap instance with RESET_PC = FE.
    rst2 = 1'b0;
    acc2_q.delete();
    cyc(12);
    check("wrap2_accepts", 32'(acc2_q.size() >= 3), 32'd1);
    if (acc2_q.size() >= 3) begin
      check("wrap2_addr0", 32'(acc2_q[0]), 32'hFE);
      check("wrap2_addr1", 32'(acc2_q[1]), 32'hFF);
      check("wrap2_addr2", 32'(acc2_q[2]), 32'h00);
    end
    check("wrap2_count", 32'(wrap2_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
